// File: rtl/bot_sync_pkg.sv
// bot_sync_pkg: shared types and constants for the rojobot update bridge.
// State encoding, default bus width and bot info field positions.
package bot_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_PEND   = 2'b10
    } bot_state_t;

    localparam int INFO_W_DEF = 32;

    localparam int LOCX_HI = 31;
    localparam int LOCX_LO = 24;
    localparam int LOCY_HI = 23;
    localparam int LOCY_LO = 16;
    localparam int SENS_HI = 15;
    localparam int SENS_LO = 8;
    localparam int INFO_HI = 7;
    localparam int INFO_LO = 0;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-flop level synchroniser for a signal from a foreign clock.
// Async active-high reset clears the whole chain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    // shift the async input through the metastability chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bot_update_sync.sv
// bot_update_sync: rojobot -> mfp_sys update bridge.
// Syncs the update strobe, snapshots the bot bus, holds pending, counts overruns.
module bot_update_sync
    import bot_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 1,
    parameter int INFO_W      = INFO_W_DEF,
    parameter int OVR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_sysregs_in,
    input  logic [INFO_W-1:0] bot_info_in,
    input  logic              int_ack,
    input  logic              overrun_clr,
    output logic [INFO_W-1:0] bot_info_out,
    output logic              bot_upd_pend,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [OVR_W-1:0] OVR_MAX  = '1;

    logic             sync_out;
    logic             sync_q;
    logic             evt;
    bot_state_t       state;
    logic [CNT_W-1:0] settle_cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (upd_sysregs_in),
        .q     (sync_out)
    );

    // registered rising-edge detect: one evt per strobe however long it is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
            evt    <= 1'b0;
        end else begin
            sync_q <= sync_out;
            evt    <= sync_out & ~sync_q;
        end
    end

    // update FSM with settle timer, snapshot, pending flag and overrun count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            bot_info_out <= '0;
            bot_upd_pend <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (evt) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= CNT_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (evt) begin
                        settle_cnt <= CNT_LOAD;
                    end else if (settle_cnt == '0) begin
                        bot_info_out <= bot_info_in;
                        bot_upd_pend <= 1'b1;
                        state        <= ST_PEND;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_PEND: begin
                    if (int_ack) begin
                        bot_upd_pend <= 1'b0;
                        if (evt) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= CNT_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (evt) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= CNT_LOAD;
                        if (overrun_cnt != OVR_MAX)
                            overrun_cnt <= overrun_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    settle_cnt   <= '0;
                    bot_upd_pend <= 1'b0;
                end
            endcase
            // a clear wins over an increment in the same cycle
            if (overrun_clr)
                overrun_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_bot_update_sync.sv
// tb_bot_update_sync: directed bench for the rojobot update bridge.
// Hand-computed expectations for latency, ack, overrun, saturation, reset.
module tb_bot_update_sync;
    import bot_sync_pkg::*;

    logic        clk;
    logic        reset;
    logic        upd_sysregs_in;
    logic [31:0] bot_info_in;
    logic        int_ack;
    logic        overrun_clr;
    logic [31:0] bot_info_out;
    logic        bot_upd_pend;
    logic [7:0]  overrun_cnt;

    int n_chk;
    int n_pass;

    bot_update_sync #(
        .SYNC_STAGES (2),
        .SETTLE      (1),
        .INFO_W      (32),
        .OVR_W       (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .upd_sysregs_in (upd_sysregs_in),
        .bot_info_in    (bot_info_in),
        .int_ack        (int_ack),
        .overrun_clr    (overrun_clr),
        .bot_info_out   (bot_info_out),
        .bot_upd_pend   (bot_upd_pend),
        .overrun_cnt    (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        upd_sysregs_in = 1'b0;
        bot_info_in = 32'hDEADBEEF;
        int_ack = 1'b0;
        overrun_clr = 1'b0;
        tick(2);
        chk("rst_pend", {31'd0, bot_upd_pend}, 32'd0);
        chk("rst_info", bot_info_out, 32'd0);
        chk("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
        reset = 1'b0;
        tick(2);

        // basic latency: strobe held 3 clocks
        bot_info_in = 32'h12345678;
        upd_sysregs_in = 1'b1;
        tick();
        chk("lat_e0", {31'd0, bot_upd_pend}, 32'd0);
        tick(2);
        upd_sysregs_in = 1'b0;
        tick();
        chk("lat_e3", {31'd0, bot_upd_pend}, 32'd0);
        tick();
        chk("lat_e4", {31'd0, bot_upd_pend}, 32'd1);
        chk("cap_basic", bot_info_out, 32'h12345678);
        tick(6);
        chk("single_evt", {24'd0, overrun_cnt}, 32'd0);

        // ack clears pending on the ack edge
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("ack_pend", {31'd0, bot_upd_pend}, 32'd0);
        bot_info_in = 32'h0BADF00D;
        int_ack = 1'b1;
        tick(3);
        int_ack = 1'b0;
        chk("idle_hold", bot_info_out, 32'h12345678);
        chk("ack_ovr", {24'd0, overrun_cnt}, 32'd0);

        // new pending update, then overrun with a newer bus value
        bot_info_in = 32'h12345678;
        upd_sysregs_in = 1'b1;
        tick(3);
        upd_sysregs_in = 1'b0;
        tick(6);
        bot_info_in = 32'hA5A5A5A5;
        upd_sysregs_in = 1'b1;
        tick(3);
        upd_sysregs_in = 1'b0;
        tick();
        chk("ovr_cnt", {24'd0, overrun_cnt}, 32'd1);
        chk("ovr_pend", {31'd0, bot_upd_pend}, 32'd1);
        chk("ovr_old", bot_info_out, 32'h12345678);
        tick();
        chk("ovr_cap", bot_info_out, 32'hA5A5A5A5);
        chk("ovr_fld", {24'd0, bot_info_out[LOCX_HI:LOCX_LO]}, 32'hA5);

        // ack coincident with a new event
        tick(4);
        bot_info_in = 32'h11223344;
        upd_sysregs_in = 1'b1;
        tick(3);
        upd_sysregs_in = 1'b0;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("sim_drop", {31'd0, bot_upd_pend}, 32'd0);
        tick();
        chk("sim_rise", {31'd0, bot_upd_pend}, 32'd1);
        chk("sim_cap", bot_info_out, 32'h11223344);
        chk("sim_ovr", {24'd0, overrun_cnt}, 32'd1);
        chk("sim_info", {24'd0, bot_info_out[INFO_HI:INFO_LO]}, 32'h44);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("clr", {24'd0, overrun_cnt}, 32'd0);

        // 260 unacked strobes: first one is not an overrun
        for (int k = 0; k < 260; k++) begin
            bot_info_in = k;
            upd_sysregs_in = 1'b1;
            tick(2);
            upd_sysregs_in = 1'b0;
            tick(2);
        end
        tick(4);
        chk("sat_cnt", {24'd0, overrun_cnt}, 32'hFF);
        chk("sat_pend", {31'd0, bot_upd_pend}, 32'd1);
        chk("sat_cap", bot_info_out, 32'd259);

        // clear coincident with an increment
        upd_sysregs_in = 1'b1;
        tick(2);
        upd_sysregs_in = 1'b0;
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("clr_win", {24'd0, overrun_cnt}, 32'd0);
        tick(3);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick(2);

        // reset in the middle of SETTLE discards the update
        bot_info_in = 32'hDEADBEEF;
        upd_sysregs_in = 1'b1;
        tick(3);
        upd_sysregs_in = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_pend", {31'd0, bot_upd_pend}, 32'd0);
        chk("mid_rst_info", bot_info_out, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("no_cap_info", bot_info_out, 32'd0);
        chk("no_cap_pend", {31'd0, bot_upd_pend}, 32'd0);

        // fresh update after reset
        bot_info_in = 32'hCAFEF00D;
        upd_sysregs_in = 1'b1;
        tick(3);
        upd_sysregs_in = 1'b0;
        tick(2);
        chk("post_rst_pend", {31'd0, bot_upd_pend}, 32'd1);
        chk("post_rst_x", {24'd0, bot_info_out[LOCX_HI:LOCX_LO]}, 32'hCA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
